// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared types and constants for the Tomasulo back end.
//   cdb_t               : one common-data-bus beat (vld, wdata, tag, wa, robid)
//   CDB_W               : width of cdb_t in bits
//   CDB_ARB_N_SRC       : default number of execution units sharing the CDB
//   CDB_ARB_FIFO_DEPTH  : default per-source result FIFO depth
// -----------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int CDB_ARB_N_SRC      = 4;
    localparam int CDB_ARB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic        vld;
        logic [31:0] wdata;
        logic [5:0]  tag;
        logic [4:0]  wa;
        logic [5:0]  robid;
    } cdb_t;

    localparam int CDB_W = $bits(cdb_t);

    // Return the beat with its valid bit forced on; sources may leave it clear.
    function automatic cdb_t cdb_mark_valid(input cdb_t c);
        cdb_t r;
        r     = c;
        r.vld = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/tomasulo_cdb_arb_fifo.sv
// -----------------------------------------------------------------------------
// tomasulo_cdb_arb_fifo
// Per-source result buffer in front of the CDB arbiter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : discard all entries (wins over push/pop)
//   push, din    : write din at the tail (caller guarantees space)
//   pop          : drop the head entry
//   head         : current head entry (valid when !empty)
//   empty        : no entries, derived from the pointer flops
//   full_r       : registered "no space" flag; a pop only clears it one
//                  cycle later, so the upstream ready is conservative
// -----------------------------------------------------------------------------
module tomasulo_cdb_arb_fifo
    import tomasulo_pkg::*;
#(
    parameter int W     = CDB_W,
    parameter int DEPTH = CDB_ARB_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full_r
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

    // Pointers carry one extra wrap bit so equal indices can mean full or empty.
    logic [AW:0]               wr_ptr_q, wr_ptr_d;
    logic [AW:0]               rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
    logic                      full_q, full_d;
    logic [AW:0]               count_s;

    assign count_s = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign full_r  = full_q;

    // Next-state for pointers, storage and the registered full flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        full_d   = full_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            full_d   = 1'b0;
        end else begin
            if (push && (count_s != DEPTH_V)) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // Pop is deliberately ignored here: space freed by a pop is
            // advertised on the following cycle.
            full_d = (count_s == DEPTH_V) || (push && (count_s == DEPTH_M1));
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
            full_q   <= full_d;
        end
    end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// -----------------------------------------------------------------------------
// tomasulo_cdb_arb
// Round-robin arbiter sharing one registered common data bus among N
// execution units, each buffered by a small result FIFO.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop all buffered results, zero the bus, reset the pointer
//   src_vld[N]   : per-source result valid
//   src_cdb      : per-source cdb_t, source i at [i*CDB_W +: CDB_W]
//   src_rdy[N]   : registered per-source accept (FIFO has space)
//   cdb_r        : registered CDB broadcast, all-zero when idle
//   stall_cnt_r  : per-source saturating stall counters, 16 bits each,
//                  present only when TOMASULO_CDB_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module tomasulo_cdb_arb
    import tomasulo_pkg::*;
#(
    parameter int N     = CDB_ARB_N_SRC,
    parameter int DEPTH = CDB_ARB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N-1:0]         src_vld,
    input  logic [N*CDB_W-1:0]   src_cdb,
    output logic [N-1:0]         src_rdy,
    output logic [CDB_W-1:0]     cdb_r
`ifdef TOMASULO_CDB_ARB_STATS_EN
    ,
    output logic [N*16-1:0]      stall_cnt_r
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    cdb_t                      cdb_q, cdb_d;
    logic [N-1:0]              push_s, pop_s, empty_s, full_s, grant_s;
    logic [N-1:0][CDB_W-1:0]   head_s;
    logic                      gnt_vld_s;
    logic [PW-1:0]             gnt_idx_s;

    assign src_rdy = ~full_s;
    assign cdb_r   = cdb_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fifo
            assign push_s[gi] = src_vld[gi] & ~full_s[gi] & ~flush;
            tomasulo_cdb_arb_fifo #(
                .W     (CDB_W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .push   (push_s[gi]),
                .din    (src_cdb[gi*CDB_W +: CDB_W]),
                .pop    (pop_s[gi]),
                .head   (head_s[gi]),
                .empty  (empty_s[gi]),
                .full_r (full_s[gi])
            );
        end
    endgenerate

    // Round-robin pick: first non-empty head scanning upward from rr_ptr_q.
    // Emptiness comes from flops, so a same-cycle push is never bypassed.
    always_comb begin
        int idx;
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!gnt_vld_s && !empty_s[idx]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = PW'(idx);
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // One-hot grant and FIFO pops; flush suppresses the pop.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_vld_s && (gnt_idx_s == PW'(i))) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
        pop_s = grant_s & ~{N{flush}};
    end

    // Bus register and pointer next-state; flush beats any grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cdb_d    = '0;
        if (flush) begin
            rr_ptr_d = '0;
            cdb_d    = '0;
        end else if (gnt_vld_s) begin
            cdb_d = cdb_mark_valid(cdb_t'(head_s[gnt_idx_s]));
            if (gnt_idx_s == PW'(N - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_s + PW'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
            cdb_d    = '0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

`ifdef TOMASULO_CDB_ARB_STATS_EN
    logic [N-1:0][15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_r = stall_cnt_q;

    // A waiting head that loses arbitration counts one stall, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < N; i++) begin
            if (!empty_s[i] && !grant_s[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
            end else begin
                stall_cnt_d[i] = stall_cnt_q[i];
            end
        end
    end

    // Stall counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// -----------------------------------------------------------------------------
// tb_tomasulo_cdb_arb
// Directed bench for tomasulo_cdb_arb (N=4, DEPTH=2). Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point, so each
// check sees the state produced by the edge just passed.
// Stats checks are compiled when TOMASULO_CDB_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_tomasulo_cdb_arb;
    import tomasulo_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [N-1:0]         src_vld;
    logic [N*CDB_W-1:0]   src_cdb;
    logic [N-1:0]         src_rdy;
    logic [CDB_W-1:0]     cdb_r;
`ifdef TOMASULO_CDB_ARB_STATS_EN
    logic [N*16-1:0]      stall_cnt_r;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    tomasulo_cdb_arb #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .src_vld     (src_vld),
        .src_cdb     (src_cdb),
        .src_rdy     (src_rdy),
        .cdb_r       (cdb_r)
`ifdef TOMASULO_CDB_ARB_STATS_EN
        ,
        .stall_cnt_r (stall_cnt_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cdb_t mk(input logic [31:0] d, input logic [5:0] t,
                                input logic [4:0] w, input logic [5:0] r);
        cdb_t c;
        c.vld   = 1'b1;
        c.wdata = d;
        c.tag   = t;
        c.wa    = w;
        c.robid = r;
        return c;
    endfunction

    // Present a result on source i; protocol requires src_rdy[i] first.
    task automatic push_req(input int i, input cdb_t c);
        check($sformatf("proto_rdy_s%0d", i), 64'(src_rdy[i]), 64'd1);
        src_vld[i]                  = 1'b1;
        src_cdb[i*CDB_W +: CDB_W]   = c;
    endtask

    task automatic idle();
        src_vld = '0;
        src_cdb = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    cdb_t c1, a0, a1, b1, b2, b3, x0, x1, y0, y1, z0, r0;
    cdb_t cexp [N];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        src_vld = '0;
        src_cdb = '0;
        tick();
        tick();
        check("rst_cdb_during", 64'(cdb_r), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_cdb", 64'(cdb_r), 64'd0);
        check("rst_rdy", 64'(src_rdy), 64'hF);

        // Single uncontended push: visible after edge t+1, gone after t+2.
        c1 = mk(32'h1234, 6'd5, 5'd3, 6'd7);
        push_req(2, c1);
        tick();
        idle();
        check("single_t", 64'(cdb_r), 64'd0);
        tick();
        check("single_t1", 64'(cdb_r), 64'(c1));
        tick();
        check("single_t2", 64'(cdb_r), 64'd0);

        // Contention from rr_ptr=0: order 0,1,2,3, then pointer back at 0.
        do_flush();
        for (int i = 0; i < N; i++) begin
            cexp[i] = mk(32'hA0 + 32'(i), 6'(i), 5'(i), 6'(i + 8));
            push_req(i, cexp[i]);
        end
        tick();
        idle();
        check("cont_rdy", 64'(src_rdy), 64'hF);
        for (int i = 0; i < N; i++) begin
            tick();
            check($sformatf("cont_gnt%0d", i), 64'(cdb_r), 64'(cexp[i]));
        end
        tick();
        check("cont_idle", 64'(cdb_r), 64'd0);
        push_req(1, cexp[1]);
        push_req(0, cexp[0]);
        tick();
        idle();
        tick();
        check("rr_back_first", 64'(cdb_r), 64'(cexp[0]));
        tick();
        check("rr_back_second", 64'(cdb_r), 64'(cexp[1]));

        // Backpressure on source 1 while source 0 competes.
        do_flush();
        a0 = mk(32'h0A00, 6'd1, 5'd1, 6'd1);
        a1 = mk(32'h0A01, 6'd2, 5'd2, 6'd2);
        b1 = mk(32'h0B01, 6'd3, 5'd3, 6'd3);
        b2 = mk(32'h0B02, 6'd4, 5'd4, 6'd4);
        b3 = mk(32'h0B03, 6'd5, 5'd5, 6'd5);
        push_req(0, a0);
        push_req(1, b1);
        tick();
        push_req(0, a1);
        push_req(1, b2);
        tick();
        idle();
        check("bp_e2_cdb", 64'(cdb_r), 64'(a0));
        check("bp_e2_rdy1", 64'(src_rdy[1]), 64'd0);
        tick();
        check("bp_e3_cdb", 64'(cdb_r), 64'(b1));
        check("bp_e3_rdy1", 64'(src_rdy[1]), 64'd0);
        check("bp_e3_rdy0", 64'(src_rdy[0]), 64'd1);
        tick();
        check("bp_e4_cdb", 64'(cdb_r), 64'(a1));
        check("bp_e4_rdy1", 64'(src_rdy[1]), 64'd1);
        push_req(1, b3);
        tick();
        idle();
        check("bp_e5_cdb", 64'(cdb_r), 64'(b2));
        tick();
        check("bp_e6_cdb", 64'(cdb_r), 64'(b3));
        tick();
        check("bp_e7_cdb", 64'(cdb_r), 64'd0);

        // Flush with entries queued in sources 0 and 3 and a push on source 1.
        do_flush();
        x0 = mk(32'hC000, 6'd10, 5'd10, 6'd10);
        x1 = mk(32'hC001, 6'd11, 5'd11, 6'd11);
        y0 = mk(32'hD000, 6'd12, 5'd12, 6'd12);
        y1 = mk(32'hD001, 6'd13, 5'd13, 6'd13);
        z0 = mk(32'hE000, 6'd14, 5'd14, 6'd14);
        push_req(0, x0);
        push_req(3, y0);
        tick();
        push_req(0, x1);
        push_req(3, y1);
        tick();
        idle();
        check("fl_pre_cdb", 64'(cdb_r), 64'(x0));
        push_req(1, z0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("fl_cdb", 64'(cdb_r), 64'd0);
        check("fl_rdy", 64'(src_rdy), 64'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("fl_after%0d", i), 64'(cdb_r), 64'd0);
        end

        // Ordering within one source.
        do_flush();
        push_req(0, mk(32'd1, 6'd1, 5'd1, 6'd1));
        tick();
        push_req(0, mk(32'd2, 6'd2, 5'd2, 6'd2));
        tick();
        idle();
        check("ord_first", 64'(cdb_r), 64'(mk(32'd1, 6'd1, 5'd1, 6'd1)));
        tick();
        check("ord_second", 64'(cdb_r), 64'(mk(32'd2, 6'd2, 5'd2, 6'd2)));
        tick();
        check("ord_idle", 64'(cdb_r), 64'd0);

        // Reset mid-operation drops the queued result.
        r0 = mk(32'hF00D, 6'd9, 5'd9, 6'd9);
        push_req(2, r0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_cdb", 64'(cdb_r), 64'd0);
        tick();
        check("rstmid_after", 64'(cdb_r), 64'd0);
        check("rstmid_rdy", 64'(src_rdy), 64'hF);

`ifdef TOMASULO_CDB_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("st_rst", 64'(stall_cnt_r), 64'd0);
        push_req(0, a0);
        push_req(1, b1);
        tick();
        idle();
        check("st_push", 64'(stall_cnt_r), 64'd0);
        tick();
        check("st_cnt1", 64'(stall_cnt_r[31:16]), 64'd1);
        check("st_cnt0", 64'(stall_cnt_r[15:0]), 64'd0);
        tick();
        check("st_cnt1_hold", 64'(stall_cnt_r[31:16]), 64'd1);
        force dut.stall_cnt_q = '1;
        #1;
        release dut.stall_cnt_q;
        push_req(0, a1);
        push_req(1, b2);
        tick();
        idle();
        tick();
        check("st_sat1", 64'(stall_cnt_r[31:16]), 64'hFFFF);
        check("st_sat0", 64'(stall_cnt_r[15:0]), 64'hFFFF);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
